tea_word_packer: RTL and testbench

- Upstream feeder for tinyenc. Accepts a byte stream on a valid/ready interface and packs every 4 bytes into one 32-bit plaintext word.
- Buffers packed words in a small FIFO and presents each one to tinyenc's wdata/req/ack port using a 4-phase handshake.
- On an end-of-message marker, a partial word is padded with a fixed byte and then sent.

---
 rtl/tea_pkg.sv | 20 ++
 rtl/tea_word_fifo.sv | 65 ++++++
 rtl/tea_word_packer.sv | 117 +++++++++++
 tb/tb_tea_word_packer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared types for the tinyenc word packer: plaintext word, handshake states, lane placement.
// Pure declarations; no timing or flow control of its own.
package tea_pkg;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } hs_state_t;

    // Bit offset of byte lane 'lane' (0 = first byte received) inside a word.
    function automatic int lane_lsb(input int lane, input bit lsb_first);
        return lsb_first ? 8 * lane : 8 * (WORD_BYTES - 1 - lane);
    endfunction

endpackage

// File: rtl/tea_word_fifo.sv
// DEPTH x 32 word FIFO; head is visible combinationally, push/pop take effect on the clock edge.
// Push while full and pop while empty are dropped; simultaneous push+pop keeps the count.
module tea_word_fifo
    import tea_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     pclk,
    input  logic                     prstb,
    input  logic                     push_i,
    input  word_t                    push_dat_i,
    input  logic                     pop_i,
    output word_t                    head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    word_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge pclk or negedge prstb) begin
        if (!prstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/tea_word_packer.sv
// Packs 4 bytes into a word and hands it to tinyenc over req/ack; word pushed on the 4th-byte edge, req one edge later.
// s_ready drops while the word FIFO is full; ack is optionally double-synchronised.
module tea_word_packer
    import tea_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter bit         LSB_FIRST = 1'b1,
    parameter int         DEPTH     = 2,
    parameter bit         ACK_SYNC  = 1'b1
) (
    input  logic        pclk,
    input  logic        prstb,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] wdata,
    output logic        req,
    input  logic        ack,
    output logic [15:0] words_sent,
    output logic        busy
);

    logic [1:0]            idx_q, idx_d;
    word_t                 asm_q, asm_d, push_word;
    logic                  accept, push, pop;
    word_t                 fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  ack_meta_q, ack_sync_q, ack_s;
    hs_state_t             state_q, state_d;
    logic [15:0]           words_sent_q, words_sent_d;
    word_t                 wdata_q, wdata_d;

    assign s_ready = ~fifo_full;
    assign accept  = s_valid & s_ready;
    assign push    = accept & ((idx_q == 2'd3) | s_last);

    // Lanes already received come from asm_q, the current lane from s_data, the rest are padding.
    always_comb begin
        asm_d     = asm_q;
        idx_d     = idx_q;
        push_word = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (k < int'(idx_q)) begin
                push_word[lane_lsb(k, LSB_FIRST) +: 8] = asm_q[lane_lsb(k, LSB_FIRST) +: 8];
            end else if (k == int'(idx_q)) begin
                push_word[lane_lsb(k, LSB_FIRST) +: 8] = s_data;
            end else begin
                push_word[lane_lsb(k, LSB_FIRST) +: 8] = PAD_BYTE;
            end
        end
        if (accept) begin
            asm_d[lane_lsb(int'(idx_q), LSB_FIRST) +: 8] = s_data;
            idx_d = push ? 2'd0 : idx_q + 2'd1;
        end
    end

    tea_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .pclk       (pclk),
        .prstb      (prstb),
        .push_i     (push),
        .push_dat_i (push_word),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign ack_s = ACK_SYNC ? ack_sync_q : ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if ((fifo_count != '0) && !ack_s) state_d = REQ;
            REQ:     if (ack_s) state_d = REL;
            REL:     if (!ack_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req          = (state_q == REQ);
        pop          = (state_q == REQ) & ack_s;
        words_sent_d = words_sent_q + 16'(pop);
        // Head only moves on a pop, which ends REQ, so wdata is stable while req is high.
        wdata_d      = fifo_empty ? wdata_q : fifo_head;
    end

    always_ff @(posedge pclk or negedge prstb) begin
        if (!prstb) begin
            idx_q        <= 2'd0;
            asm_q        <= '0;
            ack_meta_q   <= 1'b0;
            ack_sync_q   <= 1'b0;
            state_q      <= IDLE;
            words_sent_q <= '0;
            wdata_q      <= '0;
        end else begin
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            ack_meta_q   <= ack;
            ack_sync_q   <= ack_meta_q;
            state_q      <= state_d;
            words_sent_q <= words_sent_d;
            wdata_q      <= wdata_d;
        end
    end

    assign wdata      = wdata_q;
    assign words_sent = words_sent_q;
    assign busy       = (idx_q != 2'd0) | ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_tea_word_packer.sv
// Directed bench for tea_word_packer: three lane/pad configurations driven in lockstep, words checked against a scoreboard.
module tb_tea_word_packer;

    logic        pclk;
    logic        prstb;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready_v [3];
    logic [31:0] wdata_v   [3];
    logic        req_v     [3];
    logic        ack_v     [3];
    logic [15:0] ws_v      [3];
    logic        busy_v    [3];

    localparam logic [7:0] PADS [3] = '{8'h00, 8'h00, 8'h20};
    localparam bit         LSBS [3] = '{1'b1, 1'b0, 1'b1};

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] expq [3][$];
    logic [15:0] exp_sent [3];
    int          rise_cnt [3];
    logic        req_prev [3];
    logic [31:0] held     [3];
    bit          hold_ack;
    logic [7:0]  m_bytes  [4];
    int          m_idx;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    tea_word_packer #(.PAD_BYTE(8'h00), .LSB_FIRST(1'b1), .DEPTH(2), .ACK_SYNC(1'b1)) u_a (
        .pclk(pclk), .prstb(prstb), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready_v[0]), .wdata(wdata_v[0]), .req(req_v[0]), .ack(ack_v[0]),
        .words_sent(ws_v[0]), .busy(busy_v[0]));

    tea_word_packer #(.PAD_BYTE(8'h00), .LSB_FIRST(1'b0), .DEPTH(2), .ACK_SYNC(1'b1)) u_b (
        .pclk(pclk), .prstb(prstb), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready_v[1]), .wdata(wdata_v[1]), .req(req_v[1]), .ack(ack_v[1]),
        .words_sent(ws_v[1]), .busy(busy_v[1]));

    tea_word_packer #(.PAD_BYTE(8'h20), .LSB_FIRST(1'b1), .DEPTH(2), .ACK_SYNC(1'b1)) u_c (
        .pclk(pclk), .prstb(prstb), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready_v[2]), .wdata(wdata_v[2]), .req(req_v[2]), .ack(ack_v[2]),
        .words_sent(ws_v[2]), .busy(busy_v[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // tinyenc stand-in: ack follows req one cycle later unless held off.
    always @(posedge pclk or negedge prstb) begin
        for (int i = 0; i < 3; i++) begin
            if (!prstb) ack_v[i] <= 1'b0;
            else        ack_v[i] <= hold_ack ? 1'b0 : req_v[i];
        end
    end

    always @(negedge pclk) begin
        for (int i = 0; i < 3; i++) begin
            if (prstb) begin
                if (req_v[i] && !req_prev[i]) begin
                    rise_cnt[i]++;
                    check($sformatf("req_has_expected_word%0d", i), 32'(expq[i].size() != 0), 32'd1);
                    if (expq[i].size() != 0) begin
                        held[i] = expq[i].pop_front();
                        check($sformatf("wdata%0d", i), wdata_v[i], held[i]);
                    end
                end else if (req_v[i] && req_prev[i]) begin
                    check($sformatf("wdata_stable%0d", i), wdata_v[i], held[i]);
                end
            end
            req_prev[i] = req_v[i];
        end
    end

    function automatic logic [31:0] model_word(input int last_lane, input logic [7:0] pad, input bit lsb);
        logic [31:0] w;
        logic [7:0]  v;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            v = (k <= last_lane) ? m_bytes[k] : pad;
            if (lsb) w[8*k +: 8] = v;
            else     w[8*(3-k) +: 8] = v;
        end
        return w;
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit last);
        int n;
        m_bytes[m_idx] = d;
        if (m_idx == 3 || last) begin
            for (int i = 0; i < 3; i++) begin
                expq[i].push_back(model_word(m_idx, PADS[i], LSBS[i]));
                exp_sent[i]++;
            end
            m_idx = 0;
        end else begin
            m_idx++;
        end
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        n = 0;
        while (!(s_ready_v[0] && s_ready_v[1] && s_ready_v[2]) && n < 500) begin
            @(posedge pclk); #1;
            n++;
        end
        check("ready_wait", 32'(n < 500), 32'd1);
        @(posedge pclk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy_v[0] || busy_v[1] || busy_v[2] || req_v[0] || req_v[1] || req_v[2] ||
                expq[0].size() != 0 || expq[1].size() != 0 || expq[2].size() != 0) && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
        repeat (2) @(negedge pclk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("words_sent%0d", i), 32'(ws_v[i]), 32'(exp_sent[i]));
            check($sformatf("busy_idle%0d", i), 32'(busy_v[i]), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] sent_before;
        int          rise_base;
        prstb    = 1'b0;
        s_data   = 8'h00;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        hold_ack = 1'b0;
        m_idx    = 0;
        for (int i = 0; i < 3; i++) begin
            exp_sent[i] = '0;
            rise_cnt[i] = 0;
            req_prev[i] = 1'b0;
            held[i]     = '0;
        end

        repeat (2) @(negedge pclk);
        for (int i = 0; i < 3; i++) begin
            check("rst_req", 32'(req_v[i]), 32'd0);
            check("rst_wdata", wdata_v[i], 32'h0);
            check("rst_words_sent", 32'(ws_v[i]), 32'd0);
            check("rst_busy", 32'(busy_v[i]), 32'd0);
            check("rst_s_ready", 32'(s_ready_v[i]), 32'd1);
        end
        prstb = 1'b1;
        @(negedge pclk);

        // "ABCD": 44434241 LSB-first, 41424344 MSB-first; req one edge after the push.
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b0);
        send_byte(8'h44, 1'b0);
        check("req_not_on_push_edge", 32'(req_v[0]), 32'd0);
        @(posedge pclk); #1;
        check("req_next_edge", 32'(req_v[0]), 32'd1);
        drain();
        check("abcd_lsb_last_wdata", wdata_v[0], 32'h44434241);
        check("abcd_msb_last_wdata", wdata_v[1], 32'h41424344);

        // "XY" with last: zero pad and 0x20 pad.
        send_byte(8'h58, 1'b0);
        send_byte(8'h59, 1'b1);
        drain();
        check("xy_pad00", wdata_v[0], 32'h00005958);
        check("xy_pad20", wdata_v[2], 32'h20205958);

        // s_last without s_valid must do nothing.
        s_last = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        s_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("lone_last_busy", 32'(busy_v[i]), 32'd0);
            check("lone_last_req", 32'(req_v[i]), 32'd0);
        end

        // Single-byte message: three pad lanes.
        send_byte(8'h5A, 1'b1);
        drain();
        check("z_msb_pad", wdata_v[1], 32'h5A000000);

        // Backpressure with ack held low.
        sent_before = ws_v[0];
        hold_ack = 1'b1;
        for (int b = 0; b < 8; b++) send_byte(8'(8'h10 + b), 1'b0);
        for (int i = 0; i < 3; i++) check("bp_ready_low", 32'(s_ready_v[i]), 32'd0);
        repeat (5) @(posedge pclk);
        #1;
        check("bp_ready_still_low", 32'(s_ready_v[0]), 32'd0);
        check("bp_req_high", 32'(req_v[0]), 32'd1);
        check("bp_no_completion", 32'(ws_v[0]), 32'(sent_before));
        hold_ack = 1'b0;
        for (int b = 8; b < 12; b++) send_byte(8'(8'h10 + b), 1'b0);
        drain();

        // Asynchronous reset while a request is outstanding and a second word is queued.
        hold_ack = 1'b1;
        for (int b = 0; b < 8; b++) send_byte(8'(8'h30 + b), 1'b0);
        check("pre_rst_req", 32'(req_v[0]), 32'd1);
        #3;
        prstb = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("midrst_req", 32'(req_v[i]), 32'd0);
            check("midrst_busy", 32'(busy_v[i]), 32'd0);
            check("midrst_words_sent", 32'(ws_v[i]), 32'd0);
            expq[i].delete();
            exp_sent[i] = '0;
        end
        m_idx    = 0;
        hold_ack = 1'b0;
        rise_base = rise_cnt[0];
        @(negedge pclk);
        prstb = 1'b1;
        @(negedge pclk);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b0);
        send_byte(8'h64, 1'b0);
        drain();
        check("post_rst_one_req", 32'(rise_cnt[0] - rise_base), 32'd1);

        // words_sent wrap.
        @(negedge pclk);
        force u_a.words_sent_q = 16'hFFFF;
        @(negedge pclk);
        release u_a.words_sent_q;
        exp_sent[0] = 16'hFFFF;
        @(negedge pclk);
        check("preload_ffff", 32'(ws_v[0]), 32'h0000FFFF);
        send_byte(8'h71, 1'b0);
        send_byte(8'h72, 1'b0);
        send_byte(8'h73, 1'b0);
        send_byte(8'h74, 1'b0);
        drain();
        check("wrap_to_zero", 32'(ws_v[0]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
